// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding unit: EX/ID forwarding, load-use/branch stalls, mul/div scoreboard.
// Optional HAZ_PERF_EN adds a saturating stall-cycle counter on perf_stall_cnt.
module hazard_fwd_unit #(
  parameter int AW     = 5,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    id_rs,
  input  logic [AW-1:0]    id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_regwr,
  input  logic             id_is_branch,
  input  logic [AW-1:0]    ex_rs,
  input  logic [AW-1:0]    ex_rt,
  input  logic             ex_use_rs,
  input  logic             ex_use_rt,
  input  logic [AW-1:0]    ex_rd,
  input  logic             ex_regwr,
  input  logic             ex_memrd,
  input  logic [AW-1:0]    mem_rd,
  input  logic             mem_regwr,
  input  logic             mem_memrd,
  input  logic [AW-1:0]    wb_rd,
  input  logic             wb_regwr,
  input  logic             md_start,
  input  logic [AW-1:0]    md_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       cmp_a,
  output logic [1:0]       cmp_b,
  output logic             stall,
  output logic             md_busy,
  output logic             md_done,
  output logic [AW-1:0]    md_wb_rd,
  output logic [CNT_W-1:0] perf_stall_cnt
);

  localparam int CW = $clog2(MD_LAT);

  typedef enum logic {IDLE, BUSY} md_st_e;

  md_st_e        st_q, st_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] md_rd_q, md_rd_d;

  function automatic logic hit(
    input logic [AW-1:0] x,
    input logic [AW-1:0] y,
    input logic          v
  );
    return v && (x == y) && (y != '0);
  endfunction

  function automatic logic [1:0] ex_sel(
    input logic [AW-1:0] src,
    input logic          use_src,
    input logic [AW-1:0] m_rd,
    input logic          m_ok,
    input logic [AW-1:0] w_rd,
    input logic          w_ok
  );
    if (use_src && hit(src, m_rd, m_ok))      return 2'b10;
    else if (use_src && hit(src, w_rd, w_ok)) return 2'b01;
    else                                      return 2'b00;
  endfunction

  function automatic logic [1:0] id_sel(
    input logic [AW-1:0] src,
    input logic          br,
    input logic [AW-1:0] m_rd,
    input logic          m_ok,
    input logic [AW-1:0] w_rd,
    input logic          w_ok
  );
    if (br && hit(src, m_rd, m_ok))      return 2'b01;
    else if (br && hit(src, w_rd, w_ok)) return 2'b10;
    else                                 return 2'b00;
  endfunction

  logic mem_alu;
  logic mem_ld;
  logic ex_ld;

  assign mem_alu = mem_regwr & ~mem_memrd;
  assign mem_ld  = mem_regwr & mem_memrd;
  assign ex_ld   = ex_regwr & ex_memrd;

  assign fwd_a = ex_sel(ex_rs, ex_use_rs, mem_rd, mem_alu, wb_rd, wb_regwr);
  assign fwd_b = ex_sel(ex_rt, ex_use_rt, mem_rd, mem_alu, wb_rd, wb_regwr);
  assign cmp_a = id_sel(id_rs, id_is_branch, mem_rd, mem_alu, wb_rd, wb_regwr);
  assign cmp_b = id_sel(id_rt, id_is_branch, mem_rd, mem_alu, wb_rd, wb_regwr);

  logic s_ld_use;
  logic s_br_ex;
  logic s_br_ld;
  logic s_md_raw;
  logic s_md_waw;
  logic s_md_str;

  assign s_ld_use =
    (id_use_rs & hit(id_rs, ex_rd, ex_ld)) |
    (id_use_rt & hit(id_rt, ex_rd, ex_ld));
  assign s_br_ex = id_is_branch & (
    (id_use_rs & hit(id_rs, ex_rd, ex_regwr)) |
    (id_use_rt & hit(id_rt, ex_rd, ex_regwr)));
  assign s_br_ld = id_is_branch & (
    (id_use_rs & hit(id_rs, mem_rd, mem_ld)) |
    (id_use_rt & hit(id_rt, mem_rd, mem_ld)));
  assign s_md_raw = md_busy & (
    (id_use_rs & hit(id_rs, md_rd_q, 1'b1)) |
    (id_use_rt & hit(id_rt, md_rd_q, 1'b1)));
  assign s_md_waw = md_busy & hit(id_rd, md_rd_q, id_regwr);
  assign s_md_str = md_start & md_busy;

  assign stall = s_ld_use | s_br_ex | s_br_ld |
                 s_md_raw | s_md_waw | s_md_str;

  // Scoreboard: a start while BUSY is ignored here; the stall holds it upstream.
  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    unique case (st_q)
      IDLE: begin
        if (md_start) begin
          st_d    = BUSY;
          cnt_d   = CW'(MD_LAT - 1);
          md_rd_d = md_rd;
        end
      end
      BUSY: begin
        if (cnt_q == '0) st_d = IDLE;
        else             cnt_d = cnt_q - 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q    <= IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
    end else begin
      st_q    <= st_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
    end
  end

  assign md_busy  = (st_q == BUSY);
  assign md_done  = md_busy && (cnt_q == '0);
  assign md_wb_rd = md_done ? md_rd_q : '0;

`ifdef HAZ_PERF_EN
  logic [CNT_W-1:0] perf_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      perf_q <= '0;
    else if (stall && (perf_q != '1))
      perf_q <= perf_q + 1'b1;
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed scenarios plus random traffic vs a model.
// Model tracks the mul/div op as "cycles remaining" rather than FSM state.
module tb_hazard_fwd_unit;

  localparam int AW     = 5;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 32;

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] id_rs, id_rt, id_rd;
  logic id_use_rs, id_use_rt, id_regwr, id_is_branch;
  logic [AW-1:0] ex_rs, ex_rt, ex_rd;
  logic ex_use_rs, ex_use_rt, ex_regwr, ex_memrd;
  logic [AW-1:0] mem_rd, wb_rd, md_rd;
  logic mem_regwr, mem_memrd, wb_regwr, md_start;
  logic [1:0] fwd_a, fwd_b, cmp_a, cmp_b;
  logic stall, md_busy, md_done;
  logic [AW-1:0] md_wb_rd;
  logic [CNT_W-1:0] perf_stall_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  int            md_left = 0;
  logic [AW-1:0] md_dst  = '0;
  longint        perf_m  = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.AW(AW), .MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_regwr(id_regwr),
    .id_is_branch(id_is_branch),
    .ex_rs(ex_rs), .ex_rt(ex_rt),
    .ex_use_rs(ex_use_rs), .ex_use_rt(ex_use_rt),
    .ex_rd(ex_rd), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd),
    .mem_rd(mem_rd), .mem_regwr(mem_regwr), .mem_memrd(mem_memrd),
    .wb_rd(wb_rd), .wb_regwr(wb_regwr),
    .md_start(md_start), .md_rd(md_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .cmp_a(cmp_a), .cmp_b(cmp_b),
    .stall(stall), .md_busy(md_busy), .md_done(md_done),
    .md_wb_rd(md_wb_rd), .perf_stall_cnt(perf_stall_cnt)
  );

  function automatic logic mt(
    input logic [AW-1:0] x, input logic [AW-1:0] y, input logic v);
    return v && (x == y) && (y != 0);
  endfunction

  function automatic logic [1:0] m_fwd(
    input logic [AW-1:0] s, input logic u);
    if (!u) return 2'd0;
    if (mt(s, mem_rd, mem_regwr && !mem_memrd)) return 2'd2;
    if (mt(s, wb_rd, wb_regwr)) return 2'd1;
    return 2'd0;
  endfunction

  function automatic logic [1:0] m_cmp(input logic [AW-1:0] s);
    if (!id_is_branch) return 2'd0;
    if (mt(s, mem_rd, mem_regwr && !mem_memrd)) return 2'd1;
    if (mt(s, wb_rd, wb_regwr)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic logic m_stall();
    logic [AW-1:0] s [2];
    logic u [2];
    logic busy, st;
    s[0] = id_rs; s[1] = id_rt;
    u[0] = id_use_rs; u[1] = id_use_rt;
    busy = (md_left > 0);
    st = md_start && busy;
    st = st || (busy && mt(id_rd, md_dst, id_regwr));
    for (int i = 0; i < 2; i++) begin
      if (u[i]) begin
        st = st || mt(s[i], ex_rd, ex_regwr && ex_memrd);
        st = st || (id_is_branch && mt(s[i], ex_rd, ex_regwr));
        st = st || (id_is_branch &&
                    mt(s[i], mem_rd, mem_regwr && mem_memrd));
        st = st || (busy && mt(s[i], md_dst, 1'b1));
      end
    end
    return st;
  endfunction

  function automatic logic [15:0] m_vec();
    logic busy, done;
    busy = (md_left > 0);
    done = (md_left == 1);
    return {m_fwd(ex_rs, ex_use_rs), m_fwd(ex_rt, ex_use_rt),
            m_cmp(id_rs), m_cmp(id_rt), m_stall(), busy, done,
            done ? md_dst : 5'd0};
  endfunction

  // Reference timeline: md_left counts cycles the op still occupies the unit.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      md_left <= 0;
      md_dst  <= '0;
      perf_m  <= 0;
    end else begin
      if (m_stall()) perf_m <= perf_m + 1;
      if (md_left == 0) begin
        if (md_start) begin
          md_left <= MD_LAT;
          md_dst  <= md_rd;
        end
      end else begin
        md_left <= md_left - 1;
      end
    end
  end

  task automatic clr();
    id_rs = 0; id_rt = 0; id_rd = 0;
    id_use_rs = 0; id_use_rt = 0; id_regwr = 0; id_is_branch = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0;
    ex_use_rs = 0; ex_use_rt = 0; ex_regwr = 0; ex_memrd = 0;
    mem_rd = 0; mem_regwr = 0; mem_memrd = 0;
    wb_rd = 0; wb_regwr = 0; md_start = 0; md_rd = 0;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset = 0;
    clr();
    repeat (2) @(negedge clk);
    #1;
    obs = {fwd_a, fwd_b, cmp_a, cmp_b, stall, md_busy, md_done, md_wb_rd};
    n_chk++;
    if (obs !== 16'h0)
      $display("FAIL reset_outs got=%h exp=%h", obs, 16'h0);
    else n_pass++;
    n_chk++;
    if (perf_stall_cnt !== '0)
      $display("FAIL reset_perf got=%0d exp=0", perf_stall_cnt);
    else n_pass++;
    @(negedge clk);
    reset = 1;
  endtask

  task automatic test_fwd();
    @(negedge clk); clr();
    mem_rd = 3; mem_regwr = 1;
    ex_rs = 3; ex_rt = 3; ex_use_rs = 1; ex_use_rt = 1;
    #1; n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1010)
      $display("FAIL fwd_mem got=%b exp=1010", {fwd_a, fwd_b});
    else n_pass++;
    mem_regwr = 0; wb_rd = 3; wb_regwr = 1;
    #1; n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0101)
      $display("FAIL fwd_wb got=%b exp=0101", {fwd_a, fwd_b});
    else n_pass++;
    ex_rs = 0; ex_rt = 0; mem_rd = 0; mem_regwr = 1; wb_rd = 0;
    #1; n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0000)
      $display("FAIL fwd_r0 got=%b exp=0000", {fwd_a, fwd_b});
    else n_pass++;
    ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5;
    #1; n_chk++;
    if (fwd_a !== 2'b10)
      $display("FAIL fwd_prio got=%b exp=10", fwd_a);
    else n_pass++;
    mem_memrd = 1; ex_use_rt = 0;
    #1; n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0100)
      $display("FAIL fwd_memload got=%b exp=0100", {fwd_a, fwd_b});
    else n_pass++;
  endtask

  task automatic test_load_use();
    @(negedge clk); clr();
    ex_rd = 4; ex_regwr = 1; ex_memrd = 1;
    id_rs = 4; id_use_rs = 1;
    #1; n_chk++;
    if (stall !== 1'b1)
      $display("FAIL lu_stall got=%b exp=1", stall);
    else n_pass++;
    @(negedge clk); clr();
    mem_rd = 4; mem_regwr = 1; mem_memrd = 1;
    id_rs = 4; id_use_rs = 1;
    #1; n_chk++;
    if (stall !== 1'b0)
      $display("FAIL lu_release got=%b exp=0", stall);
    else n_pass++;
    @(negedge clk); clr();
    wb_rd = 4; wb_regwr = 1;
    ex_rs = 4; ex_use_rs = 1;
    #1; n_chk++;
    if (fwd_a !== 2'b01)
      $display("FAIL lu_fwd_wb got=%b exp=01", fwd_a);
    else n_pass++;
  endtask

  task automatic test_branch();
    @(negedge clk); clr();
    id_is_branch = 1; id_rs = 6; id_use_rs = 1;
    ex_rd = 6; ex_regwr = 1;
    #1; n_chk++;
    if (stall !== 1'b1)
      $display("FAIL br_ex_stall got=%b exp=1", stall);
    else n_pass++;
    @(negedge clk); clr();
    id_is_branch = 1; id_rs = 6; id_use_rs = 1;
    mem_rd = 6; mem_regwr = 1;
    #1; n_chk++;
    if ({stall, cmp_a} !== 3'b001)
      $display("FAIL br_mem got=%b exp=001", {stall, cmp_a});
    else n_pass++;
    mem_memrd = 1;
    #1; n_chk++;
    if (stall !== 1'b1)
      $display("FAIL br_load got=%b exp=1", stall);
    else n_pass++;
    mem_regwr = 0; wb_rd = 6; wb_regwr = 1;
    id_rt = 6;
    #1; n_chk++;
    if ({stall, cmp_a, cmp_b} !== 5'b01010)
      $display("FAIL br_wb got=%b exp=01010", {stall, cmp_a, cmp_b});
    else n_pass++;
  endtask

  task automatic test_md();
    @(negedge clk); clr();
    md_start = 1; md_rd = 7;
    #1; n_chk++;
    if ({md_busy, stall} !== 2'b00)
      $display("FAIL md_pre got=%b exp=00", {md_busy, stall});
    else n_pass++;
    for (int k = 1; k <= MD_LAT; k++) begin
      @(negedge clk); clr();
      case (k)
        1: begin id_rs = 7; id_use_rs = 1; end
        2: begin md_start = 1; md_rd = 9; end
        3: begin id_rd = 7; id_regwr = 1; end
        default: begin id_rt = 7; id_use_rt = 1; end
      endcase
      #1; n_chk++;
      if ({md_busy, stall, md_done} !== {2'b11, k == MD_LAT})
        $display("FAIL md_cyc%0d got=%b exp=%b", k,
                 {md_busy, stall, md_done}, {2'b11, k == MD_LAT});
      else n_pass++;
    end
    n_chk++;
    if (md_wb_rd !== 5'd7)
      $display("FAIL md_wb_rd got=%0d exp=7", md_wb_rd);
    else n_pass++;
    @(negedge clk); clr();
    id_rs = 7; id_use_rs = 1;
    #1; n_chk++;
    if ({md_busy, stall, md_done} !== 3'b000)
      $display("FAIL md_after got=%b exp=000", {md_busy, stall, md_done});
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [CNT_W-1:0] exp3;
    @(negedge clk); clr();
    md_start = 1; md_rd = 9;
    @(negedge clk); clr();
    id_rs = 9; id_use_rs = 1;
    #1; n_chk++;
    if (stall !== 1'b1)
      $display("FAIL rm_raw got=%b exp=1", stall);
    else n_pass++;
    @(negedge clk);
    reset = 0;
    #1; n_chk++;
    if ({md_busy, md_done, stall} !== 3'b000)
      $display("FAIL rm_async got=%b exp=000", {md_busy, md_done, stall});
    else n_pass++;
    n_chk++;
    if (perf_stall_cnt !== '0)
      $display("FAIL rm_perf0 got=%0d exp=0", perf_stall_cnt);
    else n_pass++;
    @(negedge clk); clr();
    reset = 1;
    ex_rd = 4; ex_regwr = 1; ex_memrd = 1;
    id_rs = 4; id_use_rs = 1;
    repeat (3) @(negedge clk);
    clr();
`ifdef HAZ_PERF_EN
    exp3 = 3;
`else
    exp3 = 0;
`endif
    #1; n_chk++;
    if (perf_stall_cnt !== exp3)
      $display("FAIL rm_perf3 got=%0d exp=%0d", perf_stall_cnt, exp3);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [15:0] obs, exp;
    logic [CNT_W-1:0] pexp;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 39) != 0);
      id_rs = AW'($urandom_range(0, 3));
      id_rt = AW'($urandom_range(0, 3));
      id_rd = AW'($urandom_range(0, 3));
      id_use_rs = 1'($urandom); id_use_rt = 1'($urandom);
      id_regwr = 1'($urandom); id_is_branch = 1'($urandom);
      ex_rs = AW'($urandom_range(0, 3));
      ex_rt = AW'($urandom_range(0, 3));
      ex_rd = AW'($urandom_range(0, 3));
      ex_use_rs = 1'($urandom); ex_use_rt = 1'($urandom);
      ex_regwr = 1'($urandom); ex_memrd = 1'($urandom);
      mem_rd = AW'($urandom_range(0, 3));
      mem_regwr = 1'($urandom); mem_memrd = 1'($urandom);
      wb_rd = AW'($urandom_range(0, 3));
      wb_regwr = 1'($urandom);
      md_start = ($urandom_range(0, 4) == 0);
      md_rd = AW'($urandom_range(0, 3));
      #1;
      obs = {fwd_a, fwd_b, cmp_a, cmp_b, stall, md_busy, md_done, md_wb_rd};
      exp = m_vec();
      n_chk++;
      if (obs !== exp)
        $display("FAIL rnd_vec c=%0d got=%h exp=%h", c, obs, exp);
      else n_pass++;
`ifdef HAZ_PERF_EN
      pexp = CNT_W'(perf_m);
`else
      pexp = '0;
`endif
      n_chk++;
      if (perf_stall_cnt !== pexp)
        $display("FAIL rnd_perf c=%0d got=%0d exp=%0d", c,
                 perf_stall_cnt, pexp);
      else n_pass++;
    end
    @(negedge clk);
    reset = 1;
    clr();
  endtask

  initial begin
    test_reset();
    test_fwd();
    test_load_use();
    test_branch();
    test_md();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
